// File: rtl/multi_adder_with_flow_control.sv
// N-operand unsigned adder: per-lane 2-entry operand FIFOs joined into a registered 2-entry result FIFO.
// Handshake: a word transfers on any rising edge where valid & ready; valid never waits on ready, and in_rdy depends only on registers.
module multi_adder_with_flow_control #(
  parameter int n_inputs  = 2,
  parameter int width     = 8,
  parameter int out_width = width + $clog2(n_inputs),
  parameter bit saturate  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [n_inputs-1:0]         in_vld,
  output logic [n_inputs-1:0]         in_rdy,
  input  logic [n_inputs*width-1:0]   in_data,
  output logic                        sum_vld,
  input  logic                        sum_rdy,
  output logic [out_width-1:0]        sum_data,
  output logic                        sum_ovf
);

  localparam int full_w = width + $clog2(n_inputs);

  logic [n_inputs-1:0][1:0]            lane_cnt_q, lane_cnt_d;
  logic [n_inputs-1:0]                 lane_wp_q, lane_wp_d;
  logic [n_inputs-1:0]                 lane_rp_q, lane_rp_d;
  logic [n_inputs-1:0][1:0][width-1:0] lane_mem_q, lane_mem_d;

  logic [1:0]                          out_cnt_q, out_cnt_d;
  logic                                out_wp_q, out_wp_d;
  logic                                out_rp_q, out_rp_d;
  logic [1:0][out_width:0]             out_mem_q, out_mem_d;

  logic [n_inputs-1:0]                 head_vld;
  logic [n_inputs-1:0][width-1:0]      head_data;
  logic [n_inputs-1:0]                 lane_wr;
  logic                                fire;
  logic                                out_pop;
  logic [full_w-1:0]                   full_sum;
  logic [out_width-1:0]                result;
  logic                                ovf;

  always_comb begin
    in_rdy    = '0;
    head_vld  = '0;
    head_data = '0;
    lane_wr   = '0;
    for (int i = 0; i < n_inputs; i++) begin
      in_rdy[i]    = (lane_cnt_q[i] != 2'd2);
      head_vld[i]  = (lane_cnt_q[i] != 2'd0);
      head_data[i] = lane_mem_q[i][lane_rp_q[i]];
      lane_wr[i]   = in_vld[i] & in_rdy[i];
    end
    // Full-check uses the registered count only, so a pop this cycle frees room for next cycle's fire.
    fire    = (&head_vld) & (out_cnt_q != 2'd2);
    sum_vld = (out_cnt_q != 2'd0);
    out_pop = sum_vld & sum_rdy;
    {sum_ovf, sum_data} = sum_vld ? out_mem_q[out_rp_q] : '0;
  end

  always_comb begin
    full_sum = '0;
    for (int i = 0; i < n_inputs; i++) begin
      full_sum = full_sum + full_w'(head_data[i]);
    end
  end

  generate
    if (out_width < full_w) begin : g_narrow
      always_comb begin
        ovf = |full_sum[full_w-1:out_width];
        if (saturate && ovf) result = '1;
        else                 result = full_sum[out_width-1:0];
      end
    end else begin : g_full
      assign ovf    = 1'b0;
      assign result = full_sum[out_width-1:0];
    end
  endgenerate

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    lane_wp_d  = lane_wp_q;
    lane_rp_d  = lane_rp_q;
    lane_mem_d = lane_mem_q;
    for (int i = 0; i < n_inputs; i++) begin
      if (lane_wr[i]) begin
        lane_mem_d[i][lane_wp_q[i]] = in_data[i*width +: width];
        lane_wp_d[i] = ~lane_wp_q[i];
      end
      if (fire) lane_rp_d[i] = ~lane_rp_q[i];
      case ({lane_wr[i], fire})
        2'b10:   lane_cnt_d[i] = lane_cnt_q[i] + 2'd1;
        2'b01:   lane_cnt_d[i] = lane_cnt_q[i] - 2'd1;
        default: lane_cnt_d[i] = lane_cnt_q[i];
      endcase
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    out_wp_d  = out_wp_q;
    out_rp_d  = out_rp_q;
    out_mem_d = out_mem_q;
    if (fire) begin
      out_mem_d[out_wp_q] = {ovf, result};
      out_wp_d = ~out_wp_q;
    end
    if (out_pop) out_rp_d = ~out_rp_q;
    case ({fire, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 2'd1;
      2'b01:   out_cnt_d = out_cnt_q - 2'd1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      lane_wp_q  <= '0;
      lane_rp_q  <= '0;
      out_cnt_q  <= '0;
      out_wp_q   <= 1'b0;
      out_rp_q   <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      lane_wp_q  <= lane_wp_d;
      lane_rp_q  <= lane_rp_d;
      out_cnt_q  <= out_cnt_d;
      out_wp_q   <= out_wp_d;
      out_rp_q   <= out_rp_d;
    end
  end

  // Storage is left uninitialised; counts alone decide what is valid.
  always_ff @(posedge clk) begin
    lane_mem_q <= lane_mem_d;
    out_mem_q  <= out_mem_d;
  end

endmodule
